// File: rtl/core_pkg.sv
// core_pkg: shared tag layout, operand and forwarding bundle types for operand capture
package core_pkg;
  localparam int XLEN = 32;
  localparam int TAG_W = 6;
  localparam logic [TAG_W-1:0] ZERO_TAG = '0;
  typedef struct packed {
    logic       fp;
    logic [4:0] addr;
  } tag_t;
  typedef struct packed {
    logic            rdy;
    tag_t            tag;
    logic [XLEN-1:0] val;
  } operand_t;
  typedef struct packed {
    logic            valid;
    tag_t            tag;
    logic [XLEN-1:0] data;
  } fwd_t;
  function automatic logic is_x0(logic [TAG_W-1:0] t);
    return t == ZERO_TAG;
  endfunction
endpackage

// File: rtl/fwd_match.sv
// fwd_match: finds the lowest-index forwarding port broadcasting a given operand tag
module fwd_match #(
  parameter int NUM_FWD = 2,
  parameter int XLEN    = 32
) (
  input  logic [core_pkg::TAG_W-1:0]         tag_i,
  input  logic [NUM_FWD-1:0]                 fwd_valid_i,
  input  logic [NUM_FWD*core_pkg::TAG_W-1:0] fwd_tag_i,
  input  logic [NUM_FWD*XLEN-1:0]            fwd_data_i,
  output logic                               hit_o,
  output logic [XLEN-1:0]                    data_o
);
  import core_pkg::*;
  // scan from the top so the lowest matching port is the last one written; x0 never matches
  always_comb begin
    hit_o = 1'b0;
    data_o = '0;
    for (int i = NUM_FWD - 1; i >= 0; i--)
      if (fwd_valid_i[i] && fwd_tag_i[i*TAG_W +: TAG_W] == tag_i && !is_x0(tag_i)) begin
        hit_o = 1'b1;
        data_o = fwd_data_i[i*XLEN +: XLEN];
      end
  end
endmodule

// File: rtl/operand_wait_buffer.sv
// operand_wait_buffer: in-order FIFO that holds instructions until both operands arrive
module operand_wait_buffer #(
  parameter int DEPTH     = 4,
  parameter int NUM_FWD   = 2,
  parameter int PAYLOAD_W = 46,
  parameter int XLEN      = core_pkg::XLEN
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [4:0]                         in_rd,
  input  logic [core_pkg::TAG_W-1:0]         in_rs1_tag,
  input  logic [XLEN-1:0]                    in_rs1_val,
  input  logic                               in_rs1_rdy,
  input  logic [core_pkg::TAG_W-1:0]         in_rs2_tag,
  input  logic [XLEN-1:0]                    in_rs2_val,
  input  logic                               in_rs2_rdy,
  input  logic [PAYLOAD_W-1:0]               in_payload,
  input  logic [NUM_FWD-1:0]                 fwd_valid,
  input  logic [NUM_FWD*core_pkg::TAG_W-1:0] fwd_tag,
  input  logic [NUM_FWD*XLEN-1:0]            fwd_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [PAYLOAD_W+2*XLEN+4:0]        out_inst,
  output logic [$clog2(DEPTH+1)-1:0]         count
);
  import core_pkg::*;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [DEPTH-1:0]     vld_q, rdy1_q, rdy2_q, hit1, hit2;
  logic [TAG_W-1:0]     tag1_q [DEPTH];
  logic [TAG_W-1:0]     tag2_q [DEPTH];
  logic [XLEN-1:0]      val1_q [DEPTH];
  logic [XLEN-1:0]      val2_q [DEPTH];
  logic [XLEN-1:0]      wdat1 [DEPTH];
  logic [XLEN-1:0]      wdat2 [DEPTH];
  logic [4:0]           rd_q [DEPTH];
  logic [PAYLOAD_W-1:0] pay_q [DEPTH];
  logic [PW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 in_hit1, in_hit2, new_rdy1, new_rdy2, enq, deq;
  logic [XLEN-1:0]      in_dat1, in_dat2, new1, new2;
  for (genvar e = 0; e < DEPTH; e++) begin : g_wake
    fwd_match #(.NUM_FWD(NUM_FWD), .XLEN(XLEN)) u_m1 (.tag_i(tag1_q[e]), .fwd_valid_i(fwd_valid),
      .fwd_tag_i(fwd_tag), .fwd_data_i(fwd_data), .hit_o(hit1[e]), .data_o(wdat1[e]));
    fwd_match #(.NUM_FWD(NUM_FWD), .XLEN(XLEN)) u_m2 (.tag_i(tag2_q[e]), .fwd_valid_i(fwd_valid),
      .fwd_tag_i(fwd_tag), .fwd_data_i(fwd_data), .hit_o(hit2[e]), .data_o(wdat2[e]));
  end
  fwd_match #(.NUM_FWD(NUM_FWD), .XLEN(XLEN)) u_in1 (.tag_i(in_rs1_tag), .fwd_valid_i(fwd_valid),
    .fwd_tag_i(fwd_tag), .fwd_data_i(fwd_data), .hit_o(in_hit1), .data_o(in_dat1));
  fwd_match #(.NUM_FWD(NUM_FWD), .XLEN(XLEN)) u_in2 (.tag_i(in_rs2_tag), .fwd_valid_i(fwd_valid),
    .fwd_tag_i(fwd_tag), .fwd_data_i(fwd_data), .hit_o(in_hit2), .data_o(in_dat2));
  assign in_ready  = (count_q < CW'(DEPTH)) && !flush;
  assign out_valid = vld_q[head_q] && rdy1_q[head_q] && rdy2_q[head_q];
  assign out_inst  = {pay_q[head_q], val2_q[head_q], val1_q[head_q], rd_q[head_q]};
  assign count     = count_q;
  assign enq       = in_valid && in_ready;
  assign deq       = out_valid && out_ready;
  // pointer/count next state and incoming operand resolution (x0, then given, then same-cycle forward)
  always_comb begin
    head_d = flush ? '0 : head_q + PW'(deq);
    tail_d = flush ? '0 : tail_q + PW'(enq);
    count_d = flush ? '0 : count_q + CW'(enq) - CW'(deq);
    new_rdy1 = is_x0(in_rs1_tag) || in_rs1_rdy || in_hit1;
    new_rdy2 = is_x0(in_rs2_tag) || in_rs2_rdy || in_hit2;
    new1 = is_x0(in_rs1_tag) ? '0 : in_rs1_rdy ? in_rs1_val : in_hit1 ? in_dat1 : '0;
    new2 = is_x0(in_rs2_tag) ? '0 : in_rs2_rdy ? in_rs2_val : in_hit2 ? in_dat2 : '0;
  end
  // pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  // entry storage: flush clears, otherwise wakeup pending operands, retire head, write tail
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      rdy1_q <= '0;
      rdy2_q <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        tag1_q[e] <= '0;
        tag2_q[e] <= '0;
        val1_q[e] <= '0;
        val2_q[e] <= '0;
        rd_q[e] <= '0;
        pay_q[e] <= '0;
      end
    end else if (flush) begin
      vld_q <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (vld_q[e] && !rdy1_q[e] && hit1[e]) begin
          rdy1_q[e] <= 1'b1;
          val1_q[e] <= wdat1[e];
        end
        if (vld_q[e] && !rdy2_q[e] && hit2[e]) begin
          rdy2_q[e] <= 1'b1;
          val2_q[e] <= wdat2[e];
        end
      end
      if (deq) vld_q[head_q] <= 1'b0;
      if (enq) begin
        vld_q[tail_q] <= 1'b1;
        rdy1_q[tail_q] <= new_rdy1;
        rdy2_q[tail_q] <= new_rdy2;
        tag1_q[tail_q] <= in_rs1_tag;
        tag2_q[tail_q] <= in_rs2_tag;
        val1_q[tail_q] <= new1;
        val2_q[tail_q] <= new2;
        rd_q[tail_q] <= in_rd;
        pay_q[tail_q] <= in_payload;
      end
    end
  end
endmodule

// File: tb/tb_operand_wait_buffer.sv
// tb_operand_wait_buffer: directed and random stimulus checked against a queue-based model
module tb_operand_wait_buffer;
  logic clk = 1'b0;
  logic rst_n, flush, in_valid, in_ready, in_rs1_rdy, in_rs2_rdy, out_valid, out_ready;
  logic [4:0] in_rd;
  logic [5:0] in_rs1_tag, in_rs2_tag;
  logic [31:0] in_rs1_val, in_rs2_val;
  logic [45:0] in_payload;
  logic [1:0] fwd_valid;
  logic [11:0] fwd_tag;
  logic [63:0] fwd_data;
  logic [114:0] out_inst, saved;
  logic [2:0] count;
  int npass = 0, nchk = 0;

  typedef struct {
    logic [4:0] rd;
    logic [5:0] t1, t2;
    logic [31:0] v1, v2;
    logic r1, r2;
    logic [45:0] pay;
  } ent_t;
  ent_t q[$];

  operand_wait_buffer dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_rs1_tag(in_rs1_tag), .in_rs1_val(in_rs1_val), .in_rs1_rdy(in_rs1_rdy),
    .in_rs2_tag(in_rs2_tag), .in_rs2_val(in_rs2_val), .in_rs2_rdy(in_rs2_rdy),
    .in_payload(in_payload), .fwd_valid(fwd_valid), .fwd_tag(fwd_tag), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [32:0] bcast(input logic [5:0] t);
    for (int i = 0; i < 2; i++)
      if (t != 6'd0 && fwd_valid[i] && fwd_tag[i*6 +: 6] == t) return {1'b1, fwd_data[i*32 +: 32]};
    return 33'd0;
  endfunction

  function automatic logic [32:0] resolve(input logic [5:0] t, input logic r, input logic [31:0] v);
    if (t == 6'd0) return {1'b1, 32'd0};
    if (r) return {1'b1, v};
    return bcast(t);
  endfunction

  task automatic idle();
    flush = 0; in_valid = 0; in_rd = 0; in_rs1_tag = 0; in_rs2_tag = 0;
    in_rs1_val = 0; in_rs2_val = 0; in_rs1_rdy = 0; in_rs2_rdy = 0; in_payload = 0;
    fwd_valid = 0; fwd_tag = 0; fwd_data = 0;
  endtask

  task automatic enq(input logic [4:0] rd, input logic [5:0] t1, input logic r1, input logic [31:0] v1,
                     input logic [5:0] t2, input logic r2, input logic [31:0] v2, input logic [45:0] pay);
    in_valid = 1; in_rd = rd; in_rs1_tag = t1; in_rs1_rdy = r1; in_rs1_val = v1;
    in_rs2_tag = t2; in_rs2_rdy = r2; in_rs2_val = v2; in_payload = pay;
  endtask

  task automatic step();
    logic ov;
    ent_t e;
    logic [32:0] w;
    #1;
    ov = q.size() > 0 && q[0].r1 && q[0].r2;
    check("in_ready", 128'(in_ready), 128'(q.size() < 4 && !flush));
    check("out_valid", 128'(out_valid), 128'(ov));
    check("count", 128'(count), 128'(q.size()));
    if (ov) check("out_inst", 128'(out_inst), 128'({q[0].pay, q[0].v2, q[0].v1, q[0].rd}));
    @(posedge clk);
    if (flush) q.delete();
    else begin
      logic do_enq;
      do_enq = in_valid && q.size() < 4;
      foreach (q[k]) begin
        if (!q[k].r1) begin w = bcast(q[k].t1); if (w[32]) begin q[k].r1 = 1; q[k].v1 = w[31:0]; end end
        if (!q[k].r2) begin w = bcast(q[k].t2); if (w[32]) begin q[k].r2 = 1; q[k].v2 = w[31:0]; end end
      end
      if (ov && out_ready) void'(q.pop_front());
      if (do_enq) begin
        e.rd = in_rd; e.t1 = in_rs1_tag; e.t2 = in_rs2_tag; e.pay = in_payload;
        {e.r1, e.v1} = resolve(in_rs1_tag, in_rs1_rdy, in_rs1_val);
        {e.r2, e.v2} = resolve(in_rs2_tag, in_rs2_rdy, in_rs2_val);
        q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [5:0] rtag();
    logic [5:0] t;
    t = 6'($urandom_range(0, 3));
    t[5] = 1'($urandom_range(0, 1));
    return t;
  endfunction

  initial begin
    idle();
    out_ready = 0;
    rst_n = 0;
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_count", 128'(count), 128'(0));
    check("rst_out_inst", 128'(out_inst), 128'(0));
    @(negedge clk);
    rst_n = 1;
    // ready pass-through
    out_ready = 1;
    enq(5'd3, 6'h01, 1, 32'h11, 6'h02, 1, 32'h22, 46'h1234);
    step();
    idle();
    check("pass_valid", 128'(out_valid), 128'(1));
    check("pass_inst", 128'(out_inst), 128'({46'h1234, 32'h22, 32'h11, 5'd3}));
    step();
    step();
    // late wakeup on port 1
    enq(5'd4, 6'h05, 0, 32'h0, 6'h06, 1, 32'h7, 46'h55);
    step();
    idle();
    step();
    fwd_valid = 2'b10; fwd_tag = {6'h05, 6'h00}; fwd_data = {32'hDEAD, 32'h0};
    step();
    idle();
    check("wake_valid", 128'(out_valid), 128'(1));
    check("wake_rs1", 128'(out_inst[36:5]), 128'(32'hDEAD));
    step();
    // same-cycle capture with lowest-port priority
    enq(5'd5, 6'h01, 1, 32'h9, 6'h21, 0, 32'h0, 46'h66);
    fwd_valid = 2'b11; fwd_tag = {6'h21, 6'h21}; fwd_data = {32'hB, 32'hA};
    step();
    idle();
    check("cap_valid", 128'(out_valid), 128'(1));
    check("cap_rs2", 128'(out_inst[68:37]), 128'(32'hA));
    step();
    // fill with a blocked head, then wake and drain in order
    for (int i = 0; i < 4; i++) begin
      if (i == 0) enq(5'd10, 6'h07, 0, 32'h0, 6'h02, 1, 32'h100, 46'h10);
      else enq(5'(10 + i), 6'h01, 1, 32'(i), 6'h02, 1, 32'(200 + i), 46'(16 + i));
      step();
    end
    idle();
    check("full_count", 128'(count), 128'(4));
    check("full_in_ready", 128'(in_ready), 128'(0));
    step();
    fwd_valid = 2'b01; fwd_tag = {6'h00, 6'h07}; fwd_data = {32'h0, 32'h77};
    step();
    idle();
    for (int i = 0; i < 5; i++) step();
    // x0 operand and backpressure
    out_ready = 0;
    enq(5'd7, 6'h00, 0, 32'hFFFF, 6'h03, 1, 32'h33, 46'h77);
    step();
    idle();
    saved = out_inst;
    for (int i = 0; i < 3; i++) step();
    check("bp_hold", 128'(out_inst), 128'(saved));
    check("bp_x0", 128'(out_inst[36:5]), 128'(0));
    out_ready = 1;
    step();
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      flush = ($urandom_range(0, 31) == 0);
      in_valid = 1'($urandom_range(0, 1));
      in_rd = 5'($urandom); in_payload = {14'($urandom), 32'($urandom)};
      in_rs1_tag = rtag(); in_rs2_tag = rtag();
      in_rs1_rdy = 1'($urandom_range(0, 1)); in_rs2_rdy = 1'($urandom_range(0, 1));
      in_rs1_val = $urandom; in_rs2_val = $urandom;
      fwd_valid = 2'($urandom); fwd_tag = {rtag(), rtag()}; fwd_data = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    idle();
    out_ready = 1;
    flush = 1;
    step();
    idle();
    // flush beats a simultaneous enqueue
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      enq(5'(i), 6'h09, 0, 32'h0, 6'h02, 1, 32'h5, 46'h1);
      step();
    end
    enq(5'd9, 6'h01, 1, 32'h1, 6'h02, 1, 32'h2, 46'h3);
    flush = 1;
    step();
    idle();
    check("flush_count", 128'(count), 128'(0));
    step();
    // asynchronous reset mid-queue
    for (int i = 0; i < 2; i++) begin
      enq(5'(i), 6'h01, 1, 32'h1, 6'h02, 1, 32'h2, 46'h3);
      step();
    end
    idle();
    #2 rst_n = 0;
    #1;
    check("arst_out_valid", 128'(out_valid), 128'(0));
    check("arst_in_ready", 128'(in_ready), 128'(1));
    check("arst_count", 128'(count), 128'(0));
    q.delete();
    @(negedge clk);
    rst_n = 1;
    step();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
